// File: rtl/uart_card_bridge_pkg.sv
// ----------------------------------------------------------------------------
// uart_card_bridge_pkg
// Purpose : shared opcode/reply byte constants, FSM state enumeration and a
//           saturating counter helper for the UART-to-card command bridge.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package uart_card_bridge_pkg;

   // Command opcodes received from the UART
   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;

   // Status bytes returned to the UART
   localparam logic [7:0] RPL_OK   = 8'h4B;
   localparam logic [7:0] RPL_BAD  = 8'h3F;
   localparam logic [7:0] RPL_TMO  = 8'h54;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WR_REQ,
      ST_WR_DATA,
      ST_WR_PAD,
      ST_RD_REQ,
      ST_RD_DATA,
      ST_REPLY
   } state_t;

   // 8-bit increment that sticks at 255
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_card_bridge_gap_timer.sv
// ----------------------------------------------------------------------------
// bridge_gap_timer
// Purpose : counts enabled clocks since the last clear and flags when the
//           count reaches TIMEOUT_CYC. TIMEOUT_CYC = 0 never expires.
// Ports   : CLOCK50   - system clock
//           RESET     - synchronous reset, active-low
//           i_clear   - zero the counter and drop expired
//           i_enable  - advance the counter this clock
//           o_expired - registered, high once TIMEOUT_CYC clocks elapsed
// ----------------------------------------------------------------------------
module bridge_gap_timer #(
   parameter int unsigned TIMEOUT_CYC = 50000000
) (
   input  logic CLOCK50,
   input  logic RESET,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);
   localparam bit TMO_ON = (TIMEOUT_CYC != 0);

   logic [CNT_W-1:0] r_cnt;
   logic             r_expired;

   // Gap counter; holds at the limit until cleared
   always_ff @(posedge CLOCK50) begin
      if (!RESET) begin
         r_cnt     <= '0;
         r_expired <= 1'b0;
      end else if (i_clear) begin
         r_cnt     <= '0;
         r_expired <= 1'b0;
      end else if (TMO_ON && i_enable && !r_expired) begin
         r_cnt     <= r_cnt + CNT_W'(1);
         r_expired <= ((r_cnt + CNT_W'(1)) == LIMIT);
      end
   end

   assign o_expired = r_expired;

endmodule

// File: rtl/uart_card_bridge.sv
// ----------------------------------------------------------------------------
// uart_card_bridge
// Purpose : parses framed 'W'/'R' commands from a UART byte stream, issues
//           card block write/read requests, streams block data both ways and
//           returns a one-byte status ('K', '?', 'T').
// Ports   : CLOCK50/RESET            - clock, synchronous active-low reset
//           RX_STB/RX_DAT/RX_ACK     - UART receive byte channel
//           TX_STB/TX_DAT/TX_ACK     - UART transmit byte channel
//           WR_STB/WR_ADDR/WR_ACK    - block write request
//           WD_STB/WD_DATA/WD_ACK    - write data byte stream
//           RD_STB/RD_ADDR/RD_ACK    - block read request
//           RES_STB/RES_DATA/RES_ACK - read data byte stream
//           BUSY                     - FSM not idle
//           ERR_CNT                  - saturating count of '?'/'T' replies
// ----------------------------------------------------------------------------
module uart_card_bridge
   import uart_card_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned BLOCK_SIZE  = 512,
   parameter int unsigned TIMEOUT_CYC = 50000000
) (
   input  logic              CLOCK50,
   input  logic              RESET,
   input  logic              RX_STB,
   input  logic [7:0]        RX_DAT,
   output logic              RX_ACK,
   output logic              TX_STB,
   output logic [7:0]        TX_DAT,
   input  logic              TX_ACK,
   output logic              WR_STB,
   output logic [ADDR_W-1:0] WR_ADDR,
   input  logic              WR_ACK,
   output logic              WD_STB,
   output logic [7:0]        WD_DATA,
   input  logic              WD_ACK,
   output logic              RD_STB,
   output logic [ADDR_W-1:0] RD_ADDR,
   input  logic              RD_ACK,
   input  logic              RES_STB,
   input  logic [7:0]        RES_DATA,
   output logic              RES_ACK,
   output logic              BUSY,
   output logic [7:0]        ERR_CNT
);

   localparam int unsigned ADDR_BYTES = ADDR_W / 8;
   localparam logic [15:0] ADDR_LAST  = 16'(ADDR_BYTES - 1);
   localparam logic [15:0] BLK_LAST   = 16'(BLOCK_SIZE - 1);

   state_t            r_state;
   logic              r_is_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_cnt;
   logic              r_rx_ack, r_res_ack;
   logic              r_tx_stb, r_wr_stb, r_wd_stb, r_rd_stb;
   logic [7:0]        r_tx_dat, r_wd_data;
   logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
   logic              r_busy;
   logic [7:0]        r_err_cnt;

   logic              w_rx_xfer, w_tx_xfer, w_wr_xfer, w_wd_xfer;
   logic              w_rd_xfer, w_res_xfer, w_expired;
   logic [ADDR_W-1:0] w_addr_shift;

   assign w_rx_xfer    = RX_STB   & r_rx_ack;
   assign w_tx_xfer    = r_tx_stb & TX_ACK;
   assign w_wr_xfer    = r_wr_stb & WR_ACK;
   assign w_wd_xfer    = r_wd_stb & WD_ACK;
   assign w_rd_xfer    = r_rd_stb & RD_ACK;
   assign w_res_xfer   = RES_STB  & r_res_ack;
   assign w_addr_shift = (r_addr << 8) | ADDR_W'(RX_DAT);

   // Inter-byte gap: only counts while a frame is waiting on the UART
   bridge_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
      .CLOCK50   (CLOCK50),
      .RESET     (RESET),
      .i_clear   (w_rx_xfer || (r_state == ST_IDLE)),
      .i_enable  ((r_state == ST_ADDR) || ((r_state == ST_WR_DATA) && !r_wd_stb)),
      .o_expired (w_expired)
   );

   // Command FSM with registered handshake outputs
   always_ff @(posedge CLOCK50) begin
      if (!RESET) begin
         r_state   <= ST_IDLE;
         r_is_wr   <= 1'b0;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_rx_ack  <= 1'b0;
         r_res_ack <= 1'b0;
         r_tx_stb  <= 1'b0;
         r_wr_stb  <= 1'b0;
         r_wd_stb  <= 1'b0;
         r_rd_stb  <= 1'b0;
         r_tx_dat  <= 8'h00;
         r_wd_data <= 8'h00;
         r_wr_addr <= '0;
         r_rd_addr <= '0;
         r_busy    <= 1'b0;
         r_err_cnt <= 8'h00;
      end else begin
         // ACKs are one-clock pulses
         r_rx_ack  <= 1'b0;
         r_res_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rx_xfer) begin
                  r_busy <= 1'b1;
                  if ((RX_DAT == OP_WRITE) || (RX_DAT == OP_READ)) begin
                     r_is_wr <= (RX_DAT == OP_WRITE);
                     r_addr  <= '0;
                     r_cnt   <= '0;
                     r_state <= ST_ADDR;
                  end else begin
                     r_tx_dat  <= RPL_BAD;
                     r_tx_stb  <= 1'b1;
                     r_err_cnt <= sat_inc8(r_err_cnt);
                     r_state   <= ST_REPLY;
                  end
               end else if (RX_STB && !r_rx_ack) begin
                  r_rx_ack <= 1'b1;
               end
            end
            ST_ADDR: begin
               // A byte landing on the expiry clock takes priority
               if (w_rx_xfer) begin
                  r_addr <= w_addr_shift;
                  r_cnt  <= r_cnt + 16'd1;
                  if (r_cnt == ADDR_LAST) begin
                     r_cnt <= '0;
                     if (r_is_wr) begin
                        r_wr_addr <= w_addr_shift;
                        r_wr_stb  <= 1'b1;
                        r_state   <= ST_WR_REQ;
                     end else begin
                        r_rd_addr <= w_addr_shift;
                        r_rd_stb  <= 1'b1;
                        r_state   <= ST_RD_REQ;
                     end
                  end
               end else if (w_expired) begin
                  r_tx_dat  <= RPL_TMO;
                  r_tx_stb  <= 1'b1;
                  r_err_cnt <= sat_inc8(r_err_cnt);
                  r_state   <= ST_REPLY;
               end else if (RX_STB && !r_rx_ack) begin
                  r_rx_ack <= 1'b1;
               end
            end
            ST_WR_REQ: begin
               if (w_wr_xfer) begin
                  r_wr_stb <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= ST_WR_DATA;
               end
            end
            ST_WR_DATA: begin
               // Single-byte stage: no new RX ack while WD_STB is pending
               if (w_wd_xfer) begin
                  r_wd_stb <= 1'b0;
                  r_cnt    <= r_cnt + 16'd1;
                  if (r_cnt == BLK_LAST) begin
                     r_tx_dat <= RPL_OK;
                     r_tx_stb <= 1'b1;
                     r_state  <= ST_REPLY;
                  end
               end else if (w_rx_xfer) begin
                  r_wd_data <= RX_DAT;
                  r_wd_stb  <= 1'b1;
               end else if (w_expired && !r_wd_stb) begin
                  r_state <= ST_WR_PAD;
               end else if (!r_wd_stb && RX_STB && !r_rx_ack) begin
                  r_rx_ack <= 1'b1;
               end
            end
            ST_WR_PAD: begin
               // Driver already owns the block: fill it with zeros
               if (w_wd_xfer) begin
                  r_wd_stb <= 1'b0;
                  r_cnt    <= r_cnt + 16'd1;
                  if (r_cnt == BLK_LAST) begin
                     r_tx_dat  <= RPL_TMO;
                     r_tx_stb  <= 1'b1;
                     r_err_cnt <= sat_inc8(r_err_cnt);
                     r_state   <= ST_REPLY;
                  end
               end else if (!r_wd_stb) begin
                  r_wd_data <= 8'h00;
                  r_wd_stb  <= 1'b1;
               end
            end
            ST_RD_REQ: begin
               if (w_rd_xfer) begin
                  r_rd_stb <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               // RES_ACK only offered once TX has drained the previous byte
               if (w_tx_xfer) begin
                  r_cnt <= r_cnt + 16'd1;
                  if (r_cnt == BLK_LAST) begin
                     r_tx_dat <= RPL_OK;
                     r_state  <= ST_REPLY;
                  end else begin
                     r_tx_stb <= 1'b0;
                  end
               end else if (w_res_xfer) begin
                  r_tx_dat <= RES_DATA;
                  r_tx_stb <= 1'b1;
               end else if (!r_tx_stb && RES_STB && !r_res_ack) begin
                  r_res_ack <= 1'b1;
               end
            end
            ST_REPLY: begin
               if (w_tx_xfer) begin
                  r_tx_stb <= 1'b0;
                  r_busy   <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign RX_ACK  = r_rx_ack;
   assign RES_ACK = r_res_ack;
   assign TX_STB  = r_tx_stb;
   assign TX_DAT  = r_tx_dat;
   assign WR_STB  = r_wr_stb;
   assign WR_ADDR = r_wr_addr;
   assign WD_STB  = r_wd_stb;
   assign WD_DATA = r_wd_data;
   assign RD_STB  = r_rd_stb;
   assign RD_ADDR = r_rd_addr;
   assign BUSY    = r_busy;
   assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_uart_card_bridge.sv
// ----------------------------------------------------------------------------
// tb_uart_card_bridge
// Purpose : directed bench for uart_card_bridge (ADDR_W=32, BLOCK_SIZE=4,
//           TIMEOUT_CYC=100) with behavioural UART and card-driver peers.
// ----------------------------------------------------------------------------
module tb_uart_card_bridge;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned BLOCK_SIZE  = 4;
   localparam int unsigned TIMEOUT_CYC = 100;

   logic              CLOCK50 = 1'b0;
   logic              RESET   = 1'b0;
   logic              RX_STB  = 1'b0;
   logic [7:0]        RX_DAT  = 8'h00;
   logic              RX_ACK;
   logic              TX_STB;
   logic [7:0]        TX_DAT;
   logic              TX_ACK  = 1'b0;
   logic              WR_STB;
   logic [ADDR_W-1:0] WR_ADDR;
   logic              WR_ACK  = 1'b0;
   logic              WD_STB;
   logic [7:0]        WD_DATA;
   logic              WD_ACK  = 1'b0;
   logic              RD_STB;
   logic [ADDR_W-1:0] RD_ADDR;
   logic              RD_ACK  = 1'b0;
   logic              RES_STB = 1'b0;
   logic [7:0]        RES_DATA = 8'h00;
   logic              RES_ACK;
   logic              BUSY;
   logic [7:0]        ERR_CNT;

   uart_card_bridge #(
      .ADDR_W(ADDR_W), .BLOCK_SIZE(BLOCK_SIZE), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .CLOCK50(CLOCK50), .RESET(RESET),
      .RX_STB(RX_STB), .RX_DAT(RX_DAT), .RX_ACK(RX_ACK),
      .TX_STB(TX_STB), .TX_DAT(TX_DAT), .TX_ACK(TX_ACK),
      .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_ACK(WR_ACK),
      .WD_STB(WD_STB), .WD_DATA(WD_DATA), .WD_ACK(WD_ACK),
      .RD_STB(RD_STB), .RD_ADDR(RD_ADDR), .RD_ACK(RD_ACK),
      .RES_STB(RES_STB), .RES_DATA(RES_DATA), .RES_ACK(RES_ACK),
      .BUSY(BUSY), .ERR_CNT(ERR_CNT)
   );

   always #5 CLOCK50 = ~CLOCK50;

   int passed = 0;
   int total  = 0;
   int rx_fail = 0;

   logic [7:0]  wd_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  res_q[$];
   int          tx_stall = 0;
   int          tx_wait  = 0;
   int          wr_wait  = 0;
   int          rd_wait  = 0;
   int          wr_req_cnt = 0;
   int          rd_req_cnt = 0;
   logic [31:0] wr_first, rd_first;
   logic [31:0] wr_addr_seen = '0;
   logic [31:0] rd_addr_seen = '0;
   bit          wr_hold_ok = 1'b1;
   bit          rd_hold_ok = 1'b1;
   bit          res_ack_d  = 1'b0;

   // Card driver: accept write request after 3 clocks, checking address hold
   initial forever begin
      @(posedge CLOCK50); #1;
      if (WR_ACK) begin
         WR_ACK = 1'b0; wr_wait = 0;
      end else if (WR_STB) begin
         if (wr_wait == 0) wr_first = WR_ADDR;
         else if (WR_ADDR !== wr_first) wr_hold_ok = 1'b0;
         wr_wait++;
         if (wr_wait >= 3) begin
            WR_ACK = 1'b1; wr_addr_seen = WR_ADDR; wr_req_cnt++;
         end
      end else wr_wait = 0;
   end

   // Card driver: accept read request after 3 clocks
   initial forever begin
      @(posedge CLOCK50); #1;
      if (RD_ACK) begin
         RD_ACK = 1'b0; rd_wait = 0;
      end else if (RD_STB) begin
         if (rd_wait == 0) rd_first = RD_ADDR;
         else if (RD_ADDR !== rd_first) rd_hold_ok = 1'b0;
         rd_wait++;
         if (rd_wait >= 3) begin
            RD_ACK = 1'b1; rd_addr_seen = RD_ADDR; rd_req_cnt++;
         end
      end else rd_wait = 0;
   end

   // Card driver: write data sink
   initial forever begin
      @(posedge CLOCK50); #1;
      if (WD_ACK) WD_ACK = 1'b0;
      else if (WD_STB) begin
         WD_ACK = 1'b1; wd_q.push_back(WD_DATA);
      end
   end

   // UART transmitter: sink with optional stall
   initial forever begin
      @(posedge CLOCK50); #1;
      if (TX_ACK) begin
         TX_ACK = 1'b0; tx_wait = 0;
      end else if (TX_STB) begin
         if (tx_wait >= tx_stall) begin
            TX_ACK = 1'b1; tx_q.push_back(TX_DAT);
         end else tx_wait++;
      end else tx_wait = 0;
   end

   // Card driver: read data source
   initial forever begin
      @(posedge CLOCK50); #1;
      if (RES_STB && res_ack_d) void'(res_q.pop_front());
      res_ack_d = RES_ACK;
      if (res_q.size() > 0) begin
         RES_STB = 1'b1; RES_DATA = res_q[0];
      end else RES_STB = 1'b0;
   end

   // One UART byte; bounded wait for the transfer edge
   task automatic send_b(input logic [7:0] b);
      bit ok = 1'b0;
      RX_DAT = b; RX_STB = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if (RX_ACK) begin ok = 1'b1; break; end
         @(posedge CLOCK50); #1;
      end
      if (ok) begin @(posedge CLOCK50); #1; end
      else rx_fail++;
      RX_STB = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int budget, output int cyc);
      cyc = 0;
      while ((tx_q.size() < n) && (cyc < budget)) begin
         @(posedge CLOCK50); #1; cyc++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLOCK50);
      #1;
   endtask

   task automatic test_reset;
      RESET = 1'b0;
      idle(3);
      total++;
      if ({RX_ACK, TX_STB, WR_STB, WD_STB, RD_STB, RES_ACK} !== 6'b0)
         $display("FAIL reset_strobes: got %b expected 000000",
                  {RX_ACK, TX_STB, WR_STB, WD_STB, RD_STB, RES_ACK});
      else passed++;
      total++;
      if ({TX_DAT, WD_DATA} !== 16'h0000)
         $display("FAIL reset_data: got %h expected 0000", {TX_DAT, WD_DATA});
      else passed++;
      total++;
      if ({WR_ADDR, RD_ADDR} !== 64'h0)
         $display("FAIL reset_addr: got %h expected 0", {WR_ADDR, RD_ADDR});
      else passed++;
      total++;
      if ({BUSY, ERR_CNT} !== 9'h000)
         $display("FAIL reset_busy_err: got %h expected 000", {BUSY, ERR_CNT});
      else passed++;
      RESET = 1'b1;
      idle(2);
   endtask

   task automatic test_write;
      logic [7:0] exp_wd [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      logic [7:0] got;
      int cyc;
      int n0 = wr_req_cnt;
      wd_q.delete(); tx_q.delete(); rx_fail = 0; wr_hold_ok = 1'b1;
      send_b(8'h57); send_b(8'h00); send_b(8'h00); send_b(8'h00); send_b(8'h10);
      total++;
      if (WR_STB !== 1'b1) $display("FAIL wr_stb_latency: got %b expected 1", WR_STB);
      else passed++;
      send_b(8'hAA); send_b(8'hBB); send_b(8'hCC); send_b(8'hDD);
      wait_tx(1, 200, cyc);
      idle(2);
      total++;
      if (rx_fail != 0) $display("FAIL wr_rx_handshake: got %0d timeouts expected 0", rx_fail);
      else passed++;
      total++;
      if (wr_addr_seen !== 32'h0000_0010 || wr_req_cnt != n0 + 1)
         $display("FAIL wr_addr: got %h (%0d reqs) expected 00000010 (1 req)",
                  wr_addr_seen, wr_req_cnt - n0);
      else passed++;
      total++;
      if (wr_hold_ok !== 1'b1) $display("FAIL wr_addr_hold: got unstable expected stable");
      else passed++;
      total++;
      if (wd_q.size() != 4) $display("FAIL wr_wd_count: got %0d expected 4", wd_q.size());
      else passed++;
      for (int i = 0; i < 4; i++) begin
         got = (i < wd_q.size()) ? wd_q[i] : 8'hxx;
         total++;
         if (got !== exp_wd[i]) $display("FAIL wr_wd_byte%0d: got %h expected %h", i, got, exp_wd[i]);
         else passed++;
      end
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total++;
      if (got !== 8'h4B || tx_q.size() != 1)
         $display("FAIL wr_reply: got %h (n=%0d) expected 4b (n=1)", got, tx_q.size());
      else passed++;
      total++;
      if ({BUSY, ERR_CNT} !== 9'h000)
         $display("FAIL wr_busy_err: got %h expected 000", {BUSY, ERR_CNT});
      else passed++;
   endtask

   task automatic test_read;
      logic [7:0] exp_tx [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h4B};
      logic [7:0] got;
      int cyc;
      tx_q.delete(); rx_fail = 0; rd_hold_ok = 1'b1; tx_stall = 10;
      res_q.push_back(8'h11); res_q.push_back(8'h22);
      res_q.push_back(8'h33); res_q.push_back(8'h44);
      send_b(8'h52); send_b(8'h00); send_b(8'h00); send_b(8'h02); send_b(8'h00);
      wait_tx(5, 600, cyc);
      idle(3);
      tx_stall = 0;
      total++;
      if (rd_addr_seen !== 32'h0000_0200 || rd_hold_ok !== 1'b1 || rx_fail != 0)
         $display("FAIL rd_addr: got %h hold=%0d rxto=%0d expected 00000200 hold=1 rxto=0",
                  rd_addr_seen, rd_hold_ok, rx_fail);
      else passed++;
      total++;
      if (tx_q.size() != 5) $display("FAIL rd_tx_count: got %0d expected 5", tx_q.size());
      else passed++;
      for (int i = 0; i < 5; i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         total++;
         if (got !== exp_tx[i]) $display("FAIL rd_tx_byte%0d: got %h expected %h", i, got, exp_tx[i]);
         else passed++;
      end
      total++;
      if (res_q.size() != 0 || BUSY !== 1'b0)
         $display("FAIL rd_drain: got res_left=%0d busy=%b expected 0/0", res_q.size(), BUSY);
      else passed++;
   endtask

   task automatic test_bad_opcode;
      logic [7:0] got;
      int cyc;
      tx_q.delete();
      send_b(8'h41);
      wait_tx(1, 100, cyc);
      idle(2);
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total++;
      if (got !== 8'h3F || tx_q.size() != 1)
         $display("FAIL bad_reply: got %h (n=%0d) expected 3f (n=1)", got, tx_q.size());
      else passed++;
      total++;
      if ({BUSY, ERR_CNT} !== {1'b0, 8'd1})
         $display("FAIL bad_busy_err: got %b/%0d expected 0/1", BUSY, ERR_CNT);
      else passed++;
   endtask

   task automatic test_wr_timeout;
      logic [7:0] exp_wd [4] = '{8'hAA, 8'h00, 8'h00, 8'h00};
      logic [7:0] got;
      int cyc;
      wd_q.delete(); tx_q.delete();
      send_b(8'h57); send_b(8'h00); send_b(8'h00); send_b(8'h00); send_b(8'h01);
      send_b(8'hAA);
      wait_tx(1, 400, cyc);
      idle(2);
      total++;
      if (cyc < 100) $display("FAIL wto_gap: got reply after %0d clocks expected >= 100", cyc);
      else passed++;
      total++;
      if (wd_q.size() != 4) $display("FAIL wto_wd_count: got %0d expected 4", wd_q.size());
      else passed++;
      for (int i = 0; i < 4; i++) begin
         got = (i < wd_q.size()) ? wd_q[i] : 8'hxx;
         total++;
         if (got !== exp_wd[i]) $display("FAIL wto_wd_byte%0d: got %h expected %h", i, got, exp_wd[i]);
         else passed++;
      end
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total++;
      if (got !== 8'h54) $display("FAIL wto_reply: got %h expected 54", got);
      else passed++;
      total++;
      if ({BUSY, ERR_CNT} !== {1'b0, 8'd2})
         $display("FAIL wto_busy_err: got %b/%0d expected 0/2", BUSY, ERR_CNT);
      else passed++;
   endtask

   task automatic test_rd_timeout;
      logic [7:0] got;
      int cyc;
      int r0 = rd_req_cnt;
      tx_q.delete();
      send_b(8'h52); send_b(8'h00);
      wait_tx(1, 400, cyc);
      idle(2);
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total++;
      if (got !== 8'h54) $display("FAIL rto_reply: got %h expected 54", got);
      else passed++;
      total++;
      if (rd_req_cnt != r0 || RD_STB !== 1'b0)
         $display("FAIL rto_no_rd: got %0d reqs expected 0", rd_req_cnt - r0);
      else passed++;
      total++;
      if ({BUSY, ERR_CNT} !== {1'b0, 8'd3})
         $display("FAIL rto_busy_err: got %b/%0d expected 0/3", BUSY, ERR_CNT);
      else passed++;
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] exp_wd [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      logic [7:0] got;
      int cyc;
      wd_q.delete(); tx_q.delete();
      send_b(8'h57); send_b(8'h00); send_b(8'h00); send_b(8'h00); send_b(8'h20);
      send_b(8'h11); send_b(8'h22);
      idle(4);
      total++;
      if (wd_q.size() != 2) $display("FAIL mid_wd_before: got %0d expected 2", wd_q.size());
      else passed++;
      RESET = 1'b0;
      idle(1);
      total++;
      if ({RX_ACK, TX_STB, WR_STB, WD_STB, RD_STB, RES_ACK, BUSY} !== 7'b0 || ERR_CNT !== 8'h00)
         $display("FAIL mid_reset: got stb/busy=%b err=%0d expected 0000000/0",
                  {RX_ACK, TX_STB, WR_STB, WD_STB, RD_STB, RES_ACK, BUSY}, ERR_CNT);
      else passed++;
      RESET = 1'b1;
      idle(150);
      total++;
      if (tx_q.size() != 0) $display("FAIL mid_no_reply: got %0d bytes expected 0", tx_q.size());
      else passed++;
      wd_q.delete(); tx_q.delete(); rx_fail = 0;
      send_b(8'h57); send_b(8'h00); send_b(8'h00); send_b(8'h00); send_b(8'h30);
      send_b(8'h01); send_b(8'h02); send_b(8'h03); send_b(8'h04);
      wait_tx(1, 200, cyc);
      idle(2);
      total++;
      if (wr_addr_seen !== 32'h0000_0030 || wd_q.size() != 4 || rx_fail != 0)
         $display("FAIL mid_after_frame: got addr=%h n=%0d expected 00000030 n=4",
                  wr_addr_seen, wd_q.size());
      else passed++;
      for (int i = 0; i < 4; i++) begin
         got = (i < wd_q.size()) ? wd_q[i] : 8'hxx;
         total++;
         if (got !== exp_wd[i]) $display("FAIL mid_wd_byte%0d: got %h expected %h", i, got, exp_wd[i]);
         else passed++;
      end
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total++;
      if (got !== 8'h4B || ERR_CNT !== 8'h00)
         $display("FAIL mid_after_reply: got %h err=%0d expected 4b err=0", got, ERR_CNT);
      else passed++;
   endtask

   initial begin
      #1;
      test_reset;
      test_write;
      test_read;
      test_bad_opcode;
      test_wr_timeout;
      test_rd_timeout;
      test_reset_mid_frame;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
